// File: rtl/quad_encoder_pkg.sv
// rtl/quad_encoder_pkg.sv - shared types and helpers for the quadrature encoder emulator
package quad_encoder_pkg;

    typedef enum logic [1:0] {
        SPD_QUARTER = 2'd0,
        SPD_HALF    = 2'd1,
        SPD_UNITY   = 2'd2,
        SPD_DOUBLE  = 2'd3
    } speed_t;

    // Encoding is the {qa,qb} pair itself so the outputs come straight off the state register
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } qstate_t;

    // Gray sequence 00->01->11->10 for dir=0, reversed for dir=1
    function automatic qstate_t next_q(input qstate_t q, input logic dir);
        qstate_t n;
        case (q)
            Q00:     n = dir ? Q10 : Q01;
            Q01:     n = dir ? Q00 : Q11;
            Q11:     n = dir ? Q01 : Q10;
            Q10:     n = dir ? Q11 : Q00;
            default: n = Q00;
        endcase
        return n;
    endfunction

    // Add two values and clamp symmetrically to +/-(2^(acc_w-1)-1); acc_w must be <= 31
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int acc_w);
        logic signed [32:0] sum;
        logic signed [32:0] lim_pos;
        logic signed [32:0] lim_neg;
        sum     = 33'(a) + 33'(b);
        lim_pos = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
        lim_neg = -lim_pos;
        if (sum > lim_pos) begin
            sum = lim_pos;
        end else if (sum < lim_neg) begin
            sum = lim_neg;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/quad_encoder_emu_if.sv
// rtl/quad_encoder_emu_if.sv - delta input and quadrature output bundle
interface quad_encoder_emu_if #(
    parameter int NUM_AXES = 2,
    parameter int DELTA_W  = 9
) ();
    import quad_encoder_pkg::*;

    logic [NUM_AXES*DELTA_W-1:0] delta;
    logic [NUM_AXES-1:0]         delta_valid;
    speed_t                      speed;
    logic [NUM_AXES-1:0]         flip;
    logic [NUM_AXES-1:0]         qa;
    logic [NUM_AXES-1:0]         qb;
    logic [NUM_AXES-1:0]         step_clk;
    logic [NUM_AXES-1:0]         step_dir;
    logic [NUM_AXES-1:0]         busy;

    modport master (
        output delta, delta_valid, speed, flip,
        input  qa, qb, step_clk, step_dir, busy
    );

    modport slave (
        input  delta, delta_valid, speed, flip,
        output qa, qb, step_clk, step_dir, busy
    );

endinterface

// File: rtl/quad_axis.sv
// rtl/quad_axis.sv - one encoder axis: delta scaling, pending accumulator, step timer, phase FSM
module quad_axis
    import quad_encoder_pkg::*;
#(
    parameter int DELTA_W      = 9,
    parameter int ACC_W        = 12,
    parameter int DIV_W        = 16,
    parameter int STEP_PERIOD  = 3000,
    parameter int BURST_THRESH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DELTA_W-1:0] delta,
    input  logic               delta_valid,
    input  speed_t             speed,
    input  logic               flip,
    output logic               qa,
    output logic               qb,
    output logic               step_clk,
    output logic               step_dir,
    output logic               busy
);

    localparam int              PERIOD_BURST = STEP_PERIOD >> 1;
    localparam logic [DIV_W-1:0] RELOAD_NORM  = DIV_W'(STEP_PERIOD - 1);
    localparam logic [DIV_W-1:0] RELOAD_BURST = DIV_W'(PERIOD_BURST - 1);

    logic signed [ACC_W-1:0] pending;
    logic [DIV_W-1:0]        counter;
    qstate_t                 q;

    logic signed [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0]        mag;
    logic [ACC_W-1:0]        shifted;
    logic signed [ACC_W-1:0] scaled;

    logic                    fire;
    logic                    dir;
    logic signed [31:0]      pend32;
    logic signed [31:0]      abs32;
    logic signed [31:0]      step32;
    logic signed [31:0]      inc32;
    logic signed [ACC_W-1:0] pend_next;
    logic [DIV_W-1:0]        reload;

    // Scale the delta on its magnitude so right shifts truncate toward zero; x2 fits in ACC_W
    always_comb begin
        d_ext = ACC_W'($signed(delta));
        mag   = d_ext[ACC_W-1] ? -d_ext : d_ext;
        case (speed)
            SPD_QUARTER: shifted = mag >> 2;
            SPD_HALF:    shifted = mag >> 1;
            SPD_UNITY:   shifted = mag;
            SPD_DOUBLE:  shifted = mag << 1;
            default:     shifted = mag;
        endcase
        scaled = d_ext[ACC_W-1] ? -$signed(shifted) : $signed(shifted);
    end

    // Step decision, next pending value and timer reload; strobe and step combine in one update
    always_comb begin
        fire      = (counter == '0) && (pending != '0);
        dir       = pending[ACC_W-1] ^ flip;
        pend32    = 32'(pending);
        abs32     = pending[ACC_W-1] ? -pend32 : pend32;
        reload    = (abs32 > BURST_THRESH) ? RELOAD_BURST : RELOAD_NORM;
        step32    = !fire ? 32'sd0 : (pending[ACC_W-1] ? -32'sd1 : 32'sd1);
        inc32     = delta_valid ? 32'(scaled) : 32'sd0;
        pend_next = ACC_W'(sat_add(pend32, inc32 - step32, ACC_W));
    end

    // Accumulator, step timer and phase FSM; outputs update on the edge that emits the step
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            counter  <= '0;
            q        <= Q00;
            step_clk <= 1'b0;
            step_dir <= 1'b0;
        end else begin
            pending <= pend_next;
            if (fire) begin
                counter  <= reload;
                q        <= next_q(q, dir);
                step_clk <= ~step_clk;
                step_dir <= dir;
            end else if (counter != '0) begin
                counter <= counter - DIV_W'(1);
            end
        end
    end

    assign qa   = q[1];
    assign qb   = q[0];
    assign busy = (pending != '0);

endmodule

// File: rtl/quad_encoder_emu.sv
// rtl/quad_encoder_emu.sv - N-axis quadrature encoder emulator top, one quad_axis per axis
module quad_encoder_emu
    import quad_encoder_pkg::*;
#(
    parameter int NUM_AXES     = 2,
    parameter int DELTA_W      = 9,
    parameter int ACC_W        = 12,
    parameter int DIV_W        = 16,
    parameter int STEP_PERIOD  = 3000,
    parameter int BURST_THRESH = 64
) (
    input logic               clk,
    input logic               reset,
    quad_encoder_emu_if.slave bus
);

    logic [NUM_AXES-1:0] qa_w;
    logic [NUM_AXES-1:0] qb_w;
    logic [NUM_AXES-1:0] step_clk_w;
    logic [NUM_AXES-1:0] step_dir_w;
    logic [NUM_AXES-1:0] busy_w;

    // Each axis is independent; the top only slices the packed buses
    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        quad_axis #(
            .DELTA_W      (DELTA_W),
            .ACC_W        (ACC_W),
            .DIV_W        (DIV_W),
            .STEP_PERIOD  (STEP_PERIOD),
            .BURST_THRESH (BURST_THRESH)
        ) u_axis (
            .clk         (clk),
            .reset       (reset),
            .delta       (bus.delta[i*DELTA_W +: DELTA_W]),
            .delta_valid (bus.delta_valid[i]),
            .speed       (bus.speed),
            .flip        (bus.flip[i]),
            .qa          (qa_w[i]),
            .qb          (qb_w[i]),
            .step_clk    (step_clk_w[i]),
            .step_dir    (step_dir_w[i]),
            .busy        (busy_w[i])
        );
    end

    assign bus.qa       = qa_w;
    assign bus.qb       = qb_w;
    assign bus.step_clk = step_clk_w;
    assign bus.step_dir = step_dir_w;
    assign bus.busy     = busy_w;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// tb/tb_quad_encoder_emu.sv - scoreboard bench for quad_encoder_emu
module tb_quad_encoder_emu;
    import quad_encoder_pkg::*;

    localparam int NA  = 2;
    localparam int DW  = 9;
    localparam int AW  = 12;
    localparam int PER = 4;
    localparam int BT  = 8;

    typedef struct {
        logic [1:0] q;
        logic       dir;
        int         cyc;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    step_t      exp0[$];
    step_t      exp1[$];
    step_t      mon_e;
    logic [1:0] model_q[2];
    logic [1:0] prev_clk = 2'b00;

    quad_encoder_emu_if #(.NUM_AXES(NA), .DELTA_W(DW)) bus ();

    quad_encoder_emu #(
        .NUM_AXES     (NA),
        .DELTA_W      (DW),
        .ACC_W        (AW),
        .DIV_W        (16),
        .STEP_PERIOD  (PER),
        .BURST_THRESH (BT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] gray_step(input logic [1:0] q, input logic dir);
        logic [1:0] n;
        case (q)
            2'b00:   n = dir ? 2'b10 : 2'b01;
            2'b01:   n = dir ? 2'b00 : 2'b11;
            2'b11:   n = dir ? 2'b01 : 2'b10;
            default: n = dir ? 2'b11 : 2'b00;
        endcase
        return n;
    endfunction

    // Push n expected steps; spacing follows |pending| before each step
    task automatic expect_run(input int axis, input int n, input logic dir,
                              input int t_first, input int start_abs);
        int    t;
        int    p;
        step_t e;
        t = t_first;
        p = start_abs;
        for (int k = 0; k < n; k++) begin
            model_q[axis] = gray_step(model_q[axis], dir);
            e.q   = model_q[axis];
            e.dir = dir;
            e.cyc = t;
            if (axis == 0) exp0.push_back(e);
            else           exp1.push_back(e);
            t = t + ((p > BT) ? PER / 2 : PER);
            p = p - 1;
        end
    endtask

    task automatic drive_delta(input int axis, input int value);
        logic [31:0] v;
        v = value;
        bus.delta[axis*DW +: DW] = v[DW-1:0];
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending expected steps axis0=%0d axis1=%0d, required 0",
                     name, exp0.size(), exp1.size());
            exp0.delete();
            exp1.delete();
        end
    endtask

    // Monitor: every step_clk toggle outside reset is popped against the scoreboard
    always @(negedge clk) begin
        for (int a = 0; a < NA; a++) begin
            if (!reset && bus.step_clk[a] !== prev_clk[a]) begin
                if ((a == 0 && exp0.size() == 0) || (a == 1 && exp1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step axis=%0d at cyc=%0d, required no step", a, cyc);
                end else begin
                    if (a == 0) mon_e = exp0.pop_front();
                    else        mon_e = exp1.pop_front();
                    checks++;
                    if ({bus.qa[a], bus.qb[a]} !== mon_e.q) begin
                        errors++;
                        $display("FAIL step_q axis=%0d got=%b want=%b", a, {bus.qa[a], bus.qb[a]}, mon_e.q);
                    end
                    checks++;
                    if (bus.step_dir[a] !== mon_e.dir) begin
                        errors++;
                        $display("FAIL step_dir axis=%0d got=%b want=%b", a, bus.step_dir[a], mon_e.dir);
                    end
                    checks++;
                    if (cyc !== mon_e.cyc) begin
                        errors++;
                        $display("FAIL step_time axis=%0d got=%0d want=%0d", a, cyc, mon_e.cyc);
                    end
                end
            end
            prev_clk[a] = bus.step_clk[a];
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.qa !== 2'b00) begin errors++; $display("FAIL reset_qa got=%b want=00", bus.qa); end
        checks++;
        if (bus.qb !== 2'b00) begin errors++; $display("FAIL reset_qb got=%b want=00", bus.qb); end
        checks++;
        if (bus.step_clk !== 2'b00) begin errors++; $display("FAIL reset_step_clk got=%b want=00", bus.step_clk); end
        checks++;
        if (bus.step_dir !== 2'b00) begin errors++; $display("FAIL reset_step_dir got=%b want=00", bus.step_dir); end
        checks++;
        if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b want=00", bus.busy); end
        reset = 1'b0;
        model_q[0] = 2'b00;
        model_q[1] = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unity_steps();
        int c;
        @(negedge clk);
        c = cyc;
        bus.speed = SPD_UNITY;
        drive_delta(0, 3);
        bus.delta_valid = 2'b01;
        expect_run(0, 3, 1'b0, c + 2, 3);
        @(negedge clk);
        bus.delta_valid = 2'b00;
        checks++;
        if (bus.busy !== 2'b01) begin errors++; $display("FAIL unity_busy_set got=%b want=01", bus.busy); end
        drain("unity", 100);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 2'b00) begin errors++; $display("FAIL unity_busy_clear got=%b want=00", bus.busy); end
        checks++;
        if ({bus.qa[0], bus.qb[0]} !== 2'b10) begin
            errors++; $display("FAIL unity_final_q got=%b want=10", {bus.qa[0], bus.qb[0]});
        end
    endtask

    task automatic test_flip_axis1();
        int c;
        @(negedge clk);
        c = cyc;
        bus.flip = 2'b10;
        drive_delta(1, -5);
        bus.delta_valid = 2'b10;
        expect_run(1, 5, 1'b0, c + 2, 5);
        @(negedge clk);
        bus.delta_valid = 2'b00;
        drain("flip", 100);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.step_clk[1] !== 1'b1) begin errors++; $display("FAIL flip_step_clk got=%b want=1", bus.step_clk[1]); end
        checks++;
        if ({bus.qa[1], bus.qb[1]} !== 2'b01) begin
            errors++; $display("FAIL flip_final_q got=%b want=01", {bus.qa[1], bus.qb[1]});
        end
    endtask

    task automatic test_speed_scaling();
        int c;
        @(negedge clk);
        bus.speed = SPD_QUARTER;
        drive_delta(0, -3);
        bus.delta_valid = 2'b01;
        @(negedge clk);
        bus.delta_valid = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL quarter_truncate busy got=%b want=0", bus.busy[0]); end
        c = cyc;
        bus.speed = SPD_DOUBLE;
        drive_delta(0, 255);
        bus.delta_valid = 2'b01;
        expect_run(0, 510, 1'b0, c + 2, 510);
        @(negedge clk);
        bus.delta_valid = 2'b00;
        drain("double", 3000);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL double_busy_clear got=%b want=0", bus.busy[0]); end
    endtask

    task automatic test_saturation();
        int c;
        @(negedge clk);
        c = cyc;
        bus.speed = SPD_DOUBLE;
        drive_delta(0, 255);
        bus.delta_valid = 2'b01;
        expect_run(0, 1, 1'b0, c + 2, 510);
        expect_run(0, 1, 1'b0, c + 4, 1529);
        expect_run(0, 2047, 1'b0, c + 6, 2047);
        repeat (5) @(negedge clk);
        bus.delta_valid = 2'b00;
        drain("saturation", 6000);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL sat_busy_clear got=%b want=0", bus.busy[0]); end
    endtask

    task automatic test_back_to_back_reverse();
        int c;
        @(negedge clk);
        c = cyc;
        bus.speed = SPD_UNITY;
        drive_delta(0, 1);
        bus.delta_valid = 2'b01;
        expect_run(0, 1, 1'b0, c + 2, 1);
        expect_run(0, 2, 1'b1, c + 6, 2);
        @(negedge clk);
        drive_delta(0, -2);
        @(negedge clk);
        bus.delta_valid = 2'b00;
        drain("reverse", 100);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.step_dir[0] !== 1'b1) begin errors++; $display("FAIL reverse_dir got=%b want=1", bus.step_dir[0]); end
        checks++;
        if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL reverse_busy got=%b want=0", bus.busy[0]); end
    endtask

    task automatic test_reset_mid_burst();
        int c;
        @(negedge clk);
        c = cyc;
        bus.speed = SPD_UNITY;
        drive_delta(0, 20);
        bus.delta_valid = 2'b01;
        expect_run(0, 3, 1'b0, c + 2, 20);
        @(negedge clk);
        bus.delta_valid = 2'b00;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL midburst_busy got=%b want=1", bus.busy[0]); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.qa, bus.qb, bus.step_clk, bus.step_dir, bus.busy} !== 10'b0) begin
            errors++;
            $display("FAIL midburst_reset_outputs got=%b want=0000000000",
                     {bus.qa, bus.qb, bus.step_clk, bus.step_dir, bus.busy});
        end
        checks++;
        if (exp0.size() != 0) begin errors++; $display("FAIL midburst_steps_before_reset got=%0d left want=0", exp0.size()); end
        exp0.delete();
        @(negedge clk);
        reset = 1'b0;
        model_q[0] = 2'b00;
        model_q[1] = 2'b00;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.busy !== 2'b00 || bus.step_clk !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b step_clk=%b want=00/00", bus.busy, bus.step_clk);
        end
    endtask

    initial begin
        bus.delta       = '0;
        bus.delta_valid = '0;
        bus.speed       = SPD_UNITY;
        bus.flip        = '0;
        model_q[0]      = 2'b00;
        model_q[1]      = 2'b00;
        test_reset();
        test_unity_steps();
        test_flip_axis1();
        test_speed_scaling();
        test_saturation();
        test_back_to_back_reverse();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
